// File: rtl/ib_switch_up_arbiter_if.sv
// Internal Bus merge port bundle: two downstream input streams and the
// single upstream output stream. All framing/handshake signals active-low.
interface ib_switch_up_arbiter_if #(
  parameter int DATA_WIDTH = 64
);
  logic [DATA_WIDTH-1:0] IN0_DATA;
  logic                  IN0_SOP_N;
  logic                  IN0_EOP_N;
  logic                  IN0_SRC_RDY_N;
  logic                  IN0_DST_RDY_N;

  logic [DATA_WIDTH-1:0] IN1_DATA;
  logic                  IN1_SOP_N;
  logic                  IN1_EOP_N;
  logic                  IN1_SRC_RDY_N;
  logic                  IN1_DST_RDY_N;

  logic [DATA_WIDTH-1:0] OUT_DATA;
  logic                  OUT_SOP_N;
  logic                  OUT_EOP_N;
  logic                  OUT_SRC_RDY_N;
  logic                  OUT_DST_RDY_N;

  // Stream producer side: drives both inputs and the upstream ready
  modport master (
    output IN0_DATA, IN0_SOP_N, IN0_EOP_N, IN0_SRC_RDY_N,
    output IN1_DATA, IN1_SOP_N, IN1_EOP_N, IN1_SRC_RDY_N,
    output OUT_DST_RDY_N,
    input  IN0_DST_RDY_N, IN1_DST_RDY_N,
    input  OUT_DATA, OUT_SOP_N, OUT_EOP_N, OUT_SRC_RDY_N
  );

  // Arbiter side
  modport slave (
    input  IN0_DATA, IN0_SOP_N, IN0_EOP_N, IN0_SRC_RDY_N,
    input  IN1_DATA, IN1_SOP_N, IN1_EOP_N, IN1_SRC_RDY_N,
    input  OUT_DST_RDY_N,
    output IN0_DST_RDY_N, IN1_DST_RDY_N,
    output OUT_DATA, OUT_SOP_N, OUT_EOP_N, OUT_SRC_RDY_N
  );
endinterface

// File: rtl/ib_switch_up_arbiter.sv
// Packet-granular round-robin merge of two IB streams onto the upstream port.
// Grant is held SOP..EOP; datapath and ready paths are purely combinational.
module ib_switch_up_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 CLK,
  input  logic                 RESET,
  ib_switch_up_arbiter_if.slave bus,
  input  logic                 CNT_CLR,
  output logic [1:0]           GRANT,
  output logic                 BUSY,
  output logic [CNT_WIDTH-1:0] PKT_CNT0,
  output logic [CNT_WIDTH-1:0] PKT_CNT1
);

  typedef enum logic [1:0] {IDLE = 2'd0, XFER0 = 2'd1, XFER1 = 2'd2} state_t;

  state_t               state_q, state_d;
  logic                 last_q, last_d;
  logic [CNT_WIDTH-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  logic                 req0, req1;
  logic                 gvld, gsel;
  logic                 sel_src_n, sel_eop_n;
  logic                 xfer, eop_xfer;
  logic [DATA_WIDTH-1:0] out_data;

  assign req0 = !bus.IN0_SRC_RDY_N && !bus.IN0_SOP_N;
  assign req1 = !bus.IN1_SRC_RDY_N && !bus.IN1_SOP_N;

  // Grant decision: locked owner while mid-packet, else round-robin on SOP
  // requests (tie goes to the input not served last). Reset masks it so the
  // outputs are idle for as long as RESET is held.
  always_comb begin
    gvld = 1'b0;
    gsel = 1'b0;
    unique case (state_q)
      XFER0:   begin gvld = 1'b1; gsel = 1'b0; end
      XFER1:   begin gvld = 1'b1; gsel = 1'b1; end
      default: begin
        gvld = req0 || req1;
        gsel = (req0 && req1) ? !last_q : req1;
      end
    endcase
    if (RESET) gvld = 1'b0;
  end

  assign sel_src_n = gsel ? bus.IN1_SRC_RDY_N : bus.IN0_SRC_RDY_N;
  assign sel_eop_n = gsel ? bus.IN1_EOP_N     : bus.IN0_EOP_N;
  assign xfer      = gvld && !sel_src_n && !bus.OUT_DST_RDY_N;
  assign eop_xfer  = xfer && !sel_eop_n;

  // State/LAST registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Next state: EOP transfer releases the port, anything else locks it
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    if (gvld) begin
      if (eop_xfer) begin
        state_d = IDLE;
        last_d  = gsel;
      end else begin
        state_d = gsel ? XFER1 : XFER0;
      end
    end
  end

  // Output mux: granted input mirrors onto OUT, ready flows back to it only
  always_comb begin
    out_data          = '0;
    bus.OUT_SOP_N     = 1'b1;
    bus.OUT_EOP_N     = 1'b1;
    bus.OUT_SRC_RDY_N = 1'b1;
    bus.IN0_DST_RDY_N = 1'b1;
    bus.IN1_DST_RDY_N = 1'b1;
    GRANT             = 2'b00;
    if (gvld) begin
      if (gsel) begin
        out_data          = bus.IN1_DATA;
        bus.OUT_SOP_N     = bus.IN1_SOP_N;
        bus.OUT_EOP_N     = bus.IN1_EOP_N;
        bus.OUT_SRC_RDY_N = bus.IN1_SRC_RDY_N;
        bus.IN1_DST_RDY_N = bus.OUT_DST_RDY_N;
        GRANT             = 2'b10;
      end else begin
        out_data          = bus.IN0_DATA;
        bus.OUT_SOP_N     = bus.IN0_SOP_N;
        bus.OUT_EOP_N     = bus.IN0_EOP_N;
        bus.OUT_SRC_RDY_N = bus.IN0_SRC_RDY_N;
        bus.IN0_DST_RDY_N = bus.OUT_DST_RDY_N;
        GRANT             = 2'b01;
      end
    end
  end

  assign bus.OUT_DATA = out_data;
  assign BUSY         = (state_q != IDLE);

  // Packet counters: clear wins over a coincident EOP increment
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (CNT_CLR) begin
      cnt0_d = '0;
      cnt1_d = '0;
    end else if (eop_xfer) begin
      if (gsel) cnt1_d = cnt1_q + CNT_WIDTH'(1);
      else      cnt0_d = cnt0_q + CNT_WIDTH'(1);
    end
  end

  // Counter registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign PKT_CNT0 = cnt0_q;
  assign PKT_CNT1 = cnt1_q;

endmodule

// File: tb/tb_ib_switch_up_arbiter.sv
// Bench for ib_switch_up_arbiter: packet queues per input, a port-ownership
// reference model and a word scoreboard checked every cycle.
module tb_ib_switch_up_arbiter;
  localparam int DW  = 64;
  localparam int CW  = 4;
  localparam int MOD = 1 << CW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cnt_clr = 1'b0;
  logic [1:0]    grant;
  logic          busy;
  logic [CW-1:0] pc0, pc1;

  ib_switch_up_arbiter_if #(.DATA_WIDTH(DW)) bus ();

  ib_switch_up_arbiter #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .CLK(clk), .RESET(rst), .bus(bus.slave), .CNT_CLR(cnt_clr),
    .GRANT(grant), .BUSY(busy), .PKT_CNT0(pc0), .PKT_CNT1(pc1)
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] data; bit sop; bit eop; } word_t;
  typedef struct { int cyc; int src; bit sop; bit eop; } xfer_t;

  word_t txq[2][$];
  xfer_t xlog[$];
  int    checks = 0, errors = 0;
  int    owner = -1, last = 1, cyc = 0, gap_pct = 0;
  int    cnt[2], pid[2];
  bit    vld[2];
  bit    stall, clr_now;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic add_pkt(input int src, input int len);
    word_t w;
    for (int k = 0; k < len; k++) begin
      w.data = {4'(src), 12'(pid[src]), 16'(k), 32'($urandom)};
      w.sop  = (k == 0);
      w.eop  = (k == len - 1);
      txq[src].push_back(w);
    end
    pid[src]++;
  endtask

  task automatic drive(input bit st, input bit clr);
    word_t h[2];
    for (int i = 0; i < 2; i++) begin
      vld[i] = (txq[i].size() > 0) && (int'($urandom_range(0, 99)) >= gap_pct);
      if (txq[i].size() > 0) h[i] = txq[i][0];
      else begin
        h[i].data = {$urandom, $urandom};
        h[i].sop  = 1'($urandom_range(0, 1));
        h[i].eop  = 1'($urandom_range(0, 1));
      end
    end
    bus.IN0_DATA = h[0].data; bus.IN0_SOP_N = !h[0].sop;
    bus.IN0_EOP_N = !h[0].eop; bus.IN0_SRC_RDY_N = !vld[0];
    bus.IN1_DATA = h[1].data; bus.IN1_SOP_N = !h[1].sop;
    bus.IN1_EOP_N = !h[1].eop; bus.IN1_SRC_RDY_N = !vld[1];
    bus.OUT_DST_RDY_N = st;
    cnt_clr = clr;
    stall   = st;
    clr_now = clr;
  endtask

  // Who should own the port this cycle: current packet owner, otherwise the
  // round-robin winner among inputs offering a valid SOP word, or nobody.
  function automatic int cand();
    bit r0 = vld[0] && txq[0][0].sop;
    bit r1 = vld[1] && txq[1][0].sop;
    if (owner >= 0) return owner;
    if (r0 && r1)   return 1 - last;
    if (r0)         return 0;
    if (r1)         return 1;
    return -1;
  endfunction

  task automatic check_outputs(input int c);
    bit act = (c >= 0) && vld[c];
    chk("grant", 64'(grant), (c < 0) ? 64'd0 : (c == 0 ? 64'd1 : 64'd2));
    chk("busy", 64'(busy), 64'(owner >= 0));
    chk("out_src_rdy_n", 64'(bus.OUT_SRC_RDY_N), 64'(!act));
    chk("in0_dst_rdy_n", 64'(bus.IN0_DST_RDY_N), 64'(!(c == 0 && !stall)));
    chk("in1_dst_rdy_n", 64'(bus.IN1_DST_RDY_N), 64'(!(c == 1 && !stall)));
    if (act) begin
      chk("out_data", bus.OUT_DATA, txq[c][0].data);
      chk("out_sop_n", 64'(bus.OUT_SOP_N), 64'(!txq[c][0].sop));
      chk("out_eop_n", 64'(bus.OUT_EOP_N), 64'(!txq[c][0].eop));
    end
    chk("pkt_cnt0", 64'(pc0), 64'(cnt[0]));
    chk("pkt_cnt1", 64'(pc1), 64'(cnt[1]));
  endtask

  task automatic model_update(input int c);
    word_t w;
    if (c >= 0 && vld[c] && !stall) begin
      w = txq[c].pop_front();
      xlog.push_back('{cyc, c, w.sop, w.eop});
      if (w.eop) begin
        owner  = -1;
        last   = c;
        cnt[c] = (cnt[c] + 1) % MOD;
      end else owner = c;
    end else if (c >= 0) owner = c;
    if (clr_now) cnt = '{0, 0};
  endtask

  task automatic step(input bit st, input bit clr);
    int c;
    drive(st, clr);
    #1;
    c = cand();
    check_outputs(c);
    @(posedge clk);
    model_update(c);
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain(input int maxc, input int stall_pct, input int clr_pct);
    int n = 0;
    while ((txq[0].size() > 0 || txq[1].size() > 0 || owner >= 0) && n < maxc) begin
      step(int'($urandom_range(0, 99)) < stall_pct, int'($urandom_range(0, 99)) < clr_pct);
      n++;
    end
    chk("drain_timeout", 64'(n < maxc), 64'd1);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_grant"}, 64'(grant), 64'd0);
    chk({tag, "_out_src_rdy_n"}, 64'(bus.OUT_SRC_RDY_N), 64'd1);
    chk({tag, "_in0_dst_rdy_n"}, 64'(bus.IN0_DST_RDY_N), 64'd1);
    chk({tag, "_in1_dst_rdy_n"}, 64'(bus.IN1_DST_RDY_N), 64'd1);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_pkt_cnt0"}, 64'(pc0), 64'd0);
    chk({tag, "_pkt_cnt1"}, 64'(pc1), 64'd0);
  endtask

  // Reset while both inputs present SOP requests: outputs must stay idle
  task automatic do_reset();
    rst = 1'b1;
    bus.IN0_SRC_RDY_N = 1'b0; bus.IN0_SOP_N = 1'b0;
    bus.IN1_SRC_RDY_N = 1'b0; bus.IN1_SOP_N = 1'b0;
    bus.OUT_DST_RDY_N = 1'b0; cnt_clr = 1'b0;
    #1;
    reset_checks("rst");
    txq[0].delete(); txq[1].delete();
    owner = -1; last = 1; cnt = '{0, 0}; vld = '{0, 0};
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic int find_cyc(input int mark, input int src, input bit want_sop);
    for (int k = mark; k < xlog.size(); k++)
      if (xlog[k].src == src && (want_sop ? xlog[k].sop : xlog[k].eop)) return xlog[k].cyc;
    return -100;
  endfunction

  initial begin
    int mark, k, e, s, c;
    bus.IN0_DATA = '0; bus.IN1_DATA = '0;
    bus.IN0_EOP_N = 1'b1; bus.IN1_EOP_N = 1'b1;
    @(negedge clk);
    do_reset();

    // Single stream: 3 x 4-word packets on IN0, full rate
    mark = xlog.size();
    for (int p = 0; p < 3; p++) add_pkt(0, 4);
    drain(40, 0, 0);
    chk("ss_words", 64'(xlog.size() - mark), 64'd12);
    chk("ss_span", 64'(xlog[xlog.size()-1].cyc - xlog[mark].cyc), 64'd11);
    chk("ss_cnt0", 64'(pc0), 64'd3);
    chk("ss_cnt1", 64'(pc1), 64'd0);

    // Fairness: 5 packets each, both requesting from the start
    do_reset();
    mark = xlog.size();
    for (int p = 0; p < 5; p++) begin
      add_pkt(0, int'($urandom_range(1, 4)));
      add_pkt(1, int'($urandom_range(1, 4)));
    end
    drain(200, 0, 0);
    k = 0;
    for (int j = mark; j < xlog.size(); j++)
      if (xlog[j].sop) begin
        chk($sformatf("fair_order_%0d", k), 64'(xlog[j].src), 64'(k % 2));
        k++;
      end
    chk("fair_pkts", 64'(k), 64'd10);
    chk("fair_cnt0", 64'(pc0), 64'd5);
    chk("fair_cnt1", 64'(pc1), 64'd5);

    // Locked grant under upstream stall
    do_reset();
    mark = xlog.size();
    add_pkt(0, 6);
    step(0, 0); step(0, 0);
    add_pkt(1, 3);
    repeat (4) step(1, 0);
    drain(50, 0, 0);
    e = find_cyc(mark, 0, 0);
    s = find_cyc(mark, 1, 1);
    chk("lock_in1_sop_after_in0_eop", 64'(s), 64'(e + 1));

    // Single-word packets from both inputs: stays idle, alternates each cycle
    do_reset();
    mark = xlog.size();
    for (int p = 0; p < 8; p++) begin add_pkt(0, 1); add_pkt(1, 1); end
    drain(40, 0, 0);
    chk("sw_span", 64'(xlog[xlog.size()-1].cyc - xlog[mark].cyc), 64'd15);
    for (int j = 0; j < 16; j++)
      chk($sformatf("sw_order_%0d", j), 64'(xlog[mark+j].src), 64'(j % 2));

    // Counter wrap then clear on a coincident EOP
    do_reset();
    for (int p = 0; p < 17; p++) add_pkt(0, 2);
    repeat (30) step(0, 0);
    chk("wrap_15", 64'(pc0), 64'd15);
    repeat (2) step(0, 0);
    chk("wrap_0", 64'(pc0), 64'd0);
    repeat (2) step(0, 0);
    chk("wrap_1", 64'(pc0), 64'd1);
    add_pkt(0, 2);
    step(0, 0);
    step(0, 1);
    chk("clr_with_eop", 64'(pc0), 64'd0);

    // Reset during word 3 of an IN1 packet
    do_reset();
    add_pkt(1, 6);
    step(0, 0); step(0, 0);
    drive(0, 0);
    #1;
    c = cand();
    check_outputs(c);
    rst = 1'b1;
    #1;
    reset_checks("midrst");
    txq[0].delete(); txq[1].delete();
    owner = -1; last = 1; cnt = '{0, 0};
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    // A stray non-SOP word must never be granted
    txq[1].push_back('{64'h0BAD_0000_0000_0001, 1'b0, 1'b1});
    step(0, 0); step(0, 0);
    txq[1].delete();
    mark = xlog.size();
    add_pkt(0, 2);
    add_pkt(1, 2);
    step(0, 0); step(0, 0);
    chk("midrst_first_src", 64'(xlog[mark].src), 64'd0);
    chk("midrst_cnt0", 64'(pc0), 64'd1);
    chk("midrst_cnt1", 64'(pc1), 64'd0);
    drain(20, 0, 0);

    // Randomized traffic with source gaps, upstream stalls and clears
    do_reset();
    gap_pct = 25;
    for (int p = 0; p < 12; p++) begin
      add_pkt(0, int'($urandom_range(1, 5)));
      add_pkt(1, int'($urandom_range(1, 5)));
    end
    drain(800, 30, 5);
    gap_pct = 0;
    step(0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
